entropy_collector: RTL and testbench

//  Consumes the 1-bit raw stream from the ROSC entropy generator and applies a

---
 rtl/entropy_collector_if.sv | 23 ++
 rtl/entropy_collector.sv | 163 ++++++++++++++++
 tb/tb_entropy_collector.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/entropy_collector_if.sv
// Downstream word stream of the entropy collector: collected word plus valid/ready handshake.
interface entropy_collector_if #(
  parameter int unsigned WordW = 32
) ();

  logic [WordW-1:0] data_out;
  logic             data_vld;
  logic             data_rdy;

  // Collector side drives the word and valid; the consumer returns ready.
  modport master (
    output data_out,
    output data_vld,
    input  data_rdy
  );

  modport slave (
    input  data_out,
    input  data_vld,
    output data_rdy
  );

endinterface

// File: rtl/entropy_collector.sv
// Raw ROSC bit stream -> repetition-count health test -> von Neumann corrector
// -> WordW-bit packer with a one-word pending buffer behind the output register.
module entropy_collector #(
  parameter int unsigned WordW    = 32,
  parameter int unsigned RepLimit = 16,
  parameter int unsigned CntW     = 6
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enb_i,
  input  logic                bit_in_i,
  input  logic                bit_vld_i,
  input  logic                bypass_i,
  input  logic                clr_i,
  entropy_collector_if.master out_if,
  output logic                health_fail_o,
  output logic                overflow_o
);

  localparam logic [CntW-1:0] CntFull = CntW'(WordW);
  localparam logic [CntW-1:0] CntLast = CntW'(WordW - 1);
  localparam logic [CntW-1:0] RunLim  = CntW'(RepLimit);
  localparam logic [CntW-1:0] RunOne  = CntW'(1);

  logic [WordW-1:0] shreg_q, shreg_d;
  logic [WordW-1:0] data_q, data_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [CntW-1:0]  run_q, run_d;
  logic             half_q, half_d;
  logic             last_q, last_d;
  logic             vld_q, vld_d;
  logic             hfail_q, hfail_d;
  logic             ovf_q, ovf_d;

  logic             sample;
  logic             xfer;
  logic             pending;
  logic             emit;
  logic             emit_bit;

  assign out_if.data_out = data_q;
  assign out_if.data_vld = vld_q;
  assign health_fail_o   = hfail_q;
  assign overflow_o      = ovf_q;

  // Next state for health test, corrector and packer.
  always_comb begin
    sample   = enb_i & bit_vld_i;
    xfer     = vld_q & out_if.data_rdy;
    pending  = (cnt_q == CntFull);
    run_d    = run_q;
    last_d   = last_q;
    hfail_d  = hfail_q;
    half_d   = half_q;
    emit     = 1'b0;
    emit_bit = bit_in_i;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    vld_d    = vld_q;
    ovf_d    = ovf_q;

    // Repetition count on raw samples; run_q == 0 marks the first sample after reset/clr.
    if (sample) begin
      last_d = bit_in_i;
      if ((run_q == '0) || (bit_in_i != last_q)) begin
        run_d = RunOne;
      end else if (run_q != '1) begin
        run_d = run_q + RunOne;
      end
      if (run_d >= RunLim) begin
        hfail_d = 1'b1;
      end
    end

    // Corrector. While half_q is set the previous raw sample was the pair's first bit,
    // so last_q doubles as the stored first bit.
    if (!enb_i) begin
      half_d = 1'b0;
    end else if (bit_vld_i) begin
      if (bypass_i) begin
        half_d = 1'b0;
        emit   = 1'b1;
      end else if (!half_q) begin
        half_d = 1'b1;
      end else begin
        half_d   = 1'b0;
        emit     = (last_q != bit_in_i);
        emit_bit = last_q;
      end
    end

    if (hfail_q) begin
      // Failed source: emit nothing and throw away everything buffered.
      half_d = 1'b0;
      cnt_d  = '0;
      vld_d  = 1'b0;
    end else begin
      if (xfer) begin
        vld_d = 1'b0;
      end
      // Pending word follows the accepted one with no bubble.
      if (pending && (!vld_q || xfer)) begin
        data_d = shreg_q;
        vld_d  = 1'b1;
        cnt_d  = '0;
      end
      if (emit) begin
        if (pending) begin
          ovf_d = 1'b1;
        end else begin
          shreg_d = {shreg_q[WordW-2:0], emit_bit};
          if (cnt_q == CntLast) begin
            if (!vld_q || xfer) begin
              data_d = shreg_d;
              vld_d  = 1'b1;
              cnt_d  = '0;
            end else begin
              cnt_d = CntFull;
            end
          end else begin
            cnt_d = cnt_q + RunOne;
          end
        end
      end
    end
  end

  // State registers; clr clears everything except the last presented word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      run_q   <= '0;
      half_q  <= 1'b0;
      last_q  <= 1'b0;
      vld_q   <= 1'b0;
      hfail_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (clr_i) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      run_q   <= '0;
      half_q  <= 1'b0;
      last_q  <= 1'b0;
      vld_q   <= 1'b0;
      hfail_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      half_q  <= half_d;
      last_q  <= last_d;
      vld_q   <= vld_d;
      hfail_q <= hfail_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_entropy_collector.sv
// Scoreboarded bench for entropy_collector: directed stimulus pushes expected words,
// a monitor pops and compares on every accepted transfer.
module tb_entropy_collector;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic enb_i = 1'b0;
  logic bit_in_i = 1'b0;
  logic bit_vld_i = 1'b0;
  logic bypass_i = 1'b0;
  logic clr_i = 1'b0;
  logic health_fail_o;
  logic overflow_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  entropy_collector_if #(.WordW(32)) out_if ();

  entropy_collector #(
    .WordW(32),
    .RepLimit(16),
    .CntW(6)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .enb_i(enb_i),
    .bit_in_i(bit_in_i),
    .bit_vld_i(bit_vld_i),
    .bypass_i(bypass_i),
    .clr_i(clr_i),
    .out_if(out_if),
    .health_fail_o(health_fail_o),
    .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted word must match the oldest expected word.
  always @(negedge clk_i) begin
    if (rst_ni && out_if.data_vld && out_if.data_rdy) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_word: got %h expected none", out_if.data_out);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (out_if.data_out !== e) begin
          n_err++;
          $display("FAIL word: got %h expected %h", out_if.data_out, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic b);
    bit_in_i  = b;
    bit_vld_i = 1'b1;
    tick();
    bit_vld_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send(w[i]);
  endtask

  task automatic pulse_clr();
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
  endtask

  initial begin
    out_if.data_rdy = 1'b0;
    #12;
    check("reset_vld", 32'(out_if.data_vld), 32'd0);
    check("reset_data", out_if.data_out, 32'd0);
    check("reset_hfail", 32'(health_fail_o), 32'd0);
    check("reset_ovf", 32'(overflow_o), 32'd0);
    rst_ni = 1'b1;
    tick();
    enb_i = 1'b1;

    // 1. Bypass, one word, ready high.
    bypass_i = 1'b1;
    out_if.data_rdy = 1'b1;
    exp_q.push_back(32'hA5A5A5A5);
    for (int i = 31; i >= 1; i--) send(1'((32'hA5A5A5A5 >> i) & 1));
    check("t1_vld_before_last", 32'(out_if.data_vld), 32'd0);
    send(1'b1);
    check("t1_vld_after_last", 32'(out_if.data_vld), 32'd1);
    check("t1_data", out_if.data_out, 32'hA5A5A5A5);
    tick();
    check("t1_vld_drop", 32'(out_if.data_vld), 32'd0);

    // 2. Corrector: groups 01,10,00,11,10 emit 0,1,1.
    bypass_i = 1'b0;
    exp_q.push_back(32'h6DB6DB6D);
    for (int g = 0; g < 11; g++) begin
      send(0); send(1); send(1); send(0); send(0);
      send(0); send(1); send(1); send(1); send(0);
    end
    tick();
    pulse_clr();
    check("t2_clr_vld", 32'(out_if.data_vld), 32'd0);
    check("t2_clr_data_hold", out_if.data_out, 32'h6DB6DB6D);

    // 3. Backpressure: word1 held, word2 pending, extra bit overflows.
    bypass_i = 1'b1;
    out_if.data_rdy = 1'b0;
    exp_q.push_back(32'h12345678);
    exp_q.push_back(32'h9ABCDEF0);
    send_word(32'h12345678);
    check("t3_w1_vld", 32'(out_if.data_vld), 32'd1);
    send_word(32'h9ABCDEF0);
    check("t3_w1_stable", out_if.data_out, 32'h12345678);
    check("t3_ovf_before", 32'(overflow_o), 32'd0);
    send(1'b1);
    check("t3_ovf_after", 32'(overflow_o), 32'd1);
    check("t3_w1_stable2", out_if.data_out, 32'h12345678);
    out_if.data_rdy = 1'b1;
    tick();
    tick();
    out_if.data_rdy = 1'b0;
    check("t3_vld_after", 32'(out_if.data_vld), 32'd0);
    check("t3_ovf_sticky", 32'(overflow_o), 32'd1);

    // 4. Repetition count, clr racing a failing sample, then restart.
    pulse_clr();
    out_if.data_rdy = 1'b1;
    for (int i = 0; i < 15; i++) send(1'b1);
    check("t4_15_clr_race_pre", 32'(health_fail_o), 32'd0);
    clr_i = 1'b1;
    send(1'b1);
    clr_i = 1'b0;
    check("t4_clr_wins", 32'(health_fail_o), 32'd0);
    for (int i = 0; i < 15; i++) send(1'b1);
    check("t4_15_ones", 32'(health_fail_o), 32'd0);
    send(1'b1);
    check("t4_16th_one", 32'(health_fail_o), 32'd1);
    tick();
    check("t4_vld_low", 32'(out_if.data_vld), 32'd0);
    pulse_clr();
    check("t4_clr_hfail", 32'(health_fail_o), 32'd0);
    exp_q.push_back(32'h0F0F0F0F);
    send_word(32'h0F0F0F0F);
    check("t4_restart_vld", 32'(out_if.data_vld), 32'd1);
    tick();

    // 6. enb low between pair bits drops the first bit.
    pulse_clr();
    bypass_i = 1'b0;
    exp_q.push_back(32'h7FFFFFFF);
    send(1'b1);
    enb_i = 1'b0;
    send(1'b0);
    enb_i = 1'b1;
    send(1'b0); send(1'b1);
    for (int i = 0; i < 31; i++) begin
      send(1'b1); send(1'b0);
    end
    tick();
    tick();

    // 5. Asynchronous reset mid-word with a word presented.
    pulse_clr();
    bypass_i = 1'b1;
    out_if.data_rdy = 1'b0;
    send_word(32'hCAFEF00D);
    check("t5_pre_vld", 32'(out_if.data_vld), 32'd1);
    check("t5_pre_data", out_if.data_out, 32'hCAFEF00D);
    for (int i = 0; i < 5; i++) send(1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    check("t5_rst_vld", 32'(out_if.data_vld), 32'd0);
    check("t5_rst_data", out_if.data_out, 32'd0);
    check("t5_rst_hfail", 32'(health_fail_o), 32'd0);
    check("t5_rst_ovf", 32'(overflow_o), 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
